// File: rtl/egg_timer_pkg.sv
// Shared constants for the egg timer controller: FSM state codes,
// edit-digit selector codes and preset digit limits.
package egg_timer_pkg;

   typedef logic [2:0] state_t;
   typedef logic [1:0] sel_t;
   typedef logic [3:0] digit_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_SET     = 3'd1;
   localparam state_t ST_LOADING = 3'd2;
   localparam state_t ST_RUN     = 3'd3;
   localparam state_t ST_PAUSE   = 3'd4;
   localparam state_t ST_ALARM   = 3'd5;

   localparam sel_t SEL_MIN_TENS = 2'd0;
   localparam sel_t SEL_MIN_ONES = 2'd1;
   localparam sel_t SEL_SEC_TENS = 2'd2;
   localparam sel_t SEL_SEC_ONES = 2'd3;

   localparam digit_t ONES_MAX     = 4'd9;
   localparam digit_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/egg_timer_if.sv
// Front panel / BCD counter bundle seen by the egg timer controller.
// master = controller side, slave = panel/counter side.
interface egg_timer_if;
   import egg_timer_pkg::*;

   logic   tick_1hz;
   logic   btn_start;
   logic   btn_set;
   logic   btn_up;
   logic   btn_down;
   digit_t cnt_min_tens;
   digit_t cnt_min_ones;
   digit_t cnt_sec_tens;
   digit_t cnt_sec_ones;
   logic   load;
   logic   enable;
   digit_t preset_min_tens;
   digit_t preset_min_ones;
   digit_t preset_sec_tens;
   digit_t preset_sec_ones;
   sel_t   edit_sel;
   logic   editing;
   logic   alarm;
   state_t state;

   modport master (
      input  tick_1hz, btn_start, btn_set, btn_up, btn_down,
      input  cnt_min_tens, cnt_min_ones, cnt_sec_tens, cnt_sec_ones,
      output load, enable, preset_min_tens, preset_min_ones,
      output preset_sec_tens, preset_sec_ones, edit_sel, editing, alarm, state
   );

   modport slave (
      output tick_1hz, btn_start, btn_set, btn_up, btn_down,
      output cnt_min_tens, cnt_min_ones, cnt_sec_tens, cnt_sec_ones,
      input  load, enable, preset_min_tens, preset_min_ones,
      input  preset_sec_tens, preset_sec_ones, edit_sel, editing, alarm, state
   );

endinterface

// File: rtl/bcd_digit_wrap.sv
// One editable preset digit: increments/decrements with wrap between 0
// and max_val. inc wins if both are asserted.
module bcd_digit_wrap
   import egg_timer_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   inc,
   input  logic   dec,
   input  digit_t max_val,
   output digit_t digit
);

   digit_t digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (inc) begin
         digit_d = (digit_q >= max_val) ? 4'd0 : digit_q + 4'd1;
      end else if (dec) begin
         digit_d = (digit_q == 4'd0 || digit_q > max_val) ? max_val : digit_q - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) digit_q <= 4'd0;
      else       digit_q <= digit_d;
   end

   assign digit = digit_q;

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer control FSM: preset editing, counter load/enable, expiry alarm.
// Optional alarm auto-clear after ALARM_SECONDS ticks: EGG_TIMER_ALARM_TIMEOUT_EN.
module egg_timer_ctrl
   import egg_timer_pkg::*;
#(
   parameter int ALARM_SECONDS = 10,
   parameter int MIN_TENS_MAX  = 9
) (
   input  logic         clk,
   input  logic         reset,
   egg_timer_if.master  bus
);

   localparam digit_t MT_MAX = 4'(MIN_TENS_MAX);

   state_t     state_q, state_d;
   sel_t       sel_q, sel_d;
   logic       load_q, load_d;
   logic       enable_q, enable_d;
   logic       editing_q, editing_d;
   logic       alarm_q, alarm_d;
   logic [3:0] inc_vec, dec_vec;
   digit_t     preset_digit [4];
   logic       cnt_zero, any_btn;

   assign cnt_zero = (bus.cnt_min_tens == 4'd0) && (bus.cnt_min_ones == 4'd0) &&
                     (bus.cnt_sec_tens == 4'd0) && (bus.cnt_sec_ones == 4'd0);
   assign any_btn  = bus.btn_start | bus.btn_set | bus.btn_up | bus.btn_down;

`ifdef EGG_TIMER_ALARM_TIMEOUT_EN
   localparam logic [7:0] ALARM_TICKS = 8'(ALARM_SECONDS);
   logic [7:0] alarm_cnt_q, alarm_cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) alarm_cnt_q <= 8'd0;
      else       alarm_cnt_q <= alarm_cnt_d;
   end
`else
   // Alarm duration has no effect unless the timeout build is selected.
   if (ALARM_SECONDS < 1) begin : g_alarm_seconds_unused
   end
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      inc_vec = 4'd0;
      dec_vec = 4'd0;
`ifdef EGG_TIMER_ALARM_TIMEOUT_EN
      alarm_cnt_d = alarm_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // A start with an empty counter is swallowed, not passed to set.
            if (bus.btn_start) begin
               if (!cnt_zero) state_d = ST_RUN;
            end else if (bus.btn_set) begin
               state_d = ST_SET;
               sel_d   = SEL_MIN_TENS;
            end
         end
         ST_SET: begin
            if (bus.btn_start) begin
               state_d = ST_LOADING;
               sel_d   = SEL_MIN_TENS;
            end else if (bus.btn_set) begin
               if (sel_q == SEL_SEC_ONES) begin
                  state_d = ST_LOADING;
                  sel_d   = SEL_MIN_TENS;
               end else begin
                  sel_d = sel_q + 2'd1;
               end
            end else if (bus.btn_up) begin
               inc_vec[sel_q] = 1'b1;
            end else if (bus.btn_down) begin
               dec_vec[sel_q] = 1'b1;
            end
         end
         ST_LOADING: begin
            if (bus.tick_1hz) state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (cnt_zero)           state_d = ST_ALARM;
            else if (bus.btn_start) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (bus.btn_start) begin
               state_d = ST_RUN;
            end else if (bus.btn_set) begin
               state_d = ST_SET;
               sel_d   = SEL_MIN_TENS;
            end
         end
         ST_ALARM: begin
            if (any_btn) begin
               state_d = ST_IDLE;
            end
`ifdef EGG_TIMER_ALARM_TIMEOUT_EN
            else if (bus.tick_1hz) begin
               if (alarm_cnt_q >= ALARM_TICKS - 8'd1) state_d = ST_IDLE;
               else                                   alarm_cnt_d = alarm_cnt_q + 8'd1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef EGG_TIMER_ALARM_TIMEOUT_EN
      if (state_d == ST_ALARM && state_q != ST_ALARM) alarm_cnt_d = 8'd0;
`endif
   end

   // Outputs are decoded from the next state so they land with the state change.
   always_comb begin
      load_d    = (state_d == ST_LOADING);
      enable_d  = (state_d == ST_RUN);
      editing_d = (state_d == ST_SET);
      alarm_d   = (state_d == ST_ALARM);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         sel_q     <= SEL_MIN_TENS;
         load_q    <= 1'b0;
         enable_q  <= 1'b0;
         editing_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         load_q    <= load_d;
         enable_q  <= enable_d;
         editing_q <= editing_d;
         alarm_q   <= alarm_d;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam digit_t DIGIT_MAX = (gi == 0) ? MT_MAX :
                                     (gi == 2) ? SEC_TENS_MAX : ONES_MAX;
      bcd_digit_wrap u_digit (
         .clk     (clk),
         .reset   (reset),
         .inc     (inc_vec[gi]),
         .dec     (dec_vec[gi]),
         .max_val (DIGIT_MAX),
         .digit   (preset_digit[gi])
      );
   end

   assign bus.preset_min_tens = preset_digit[SEL_MIN_TENS];
   assign bus.preset_min_ones = preset_digit[SEL_MIN_ONES];
   assign bus.preset_sec_tens = preset_digit[SEL_SEC_TENS];
   assign bus.preset_sec_ones = preset_digit[SEL_SEC_ONES];
   assign bus.load            = load_q;
   assign bus.enable          = enable_q;
   assign bus.editing         = editing_q;
   assign bus.alarm           = alarm_q;
   assign bus.edit_sel        = sel_q;
   assign bus.state           = state_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed, table-driven bench for egg_timer_ctrl (MIN_TENS_MAX = 9,
// ALARM_SECONDS = 10); timeout sequence only with EGG_TIMER_ALARM_TIMEOUT_EN.
module tb_egg_timer_ctrl;

   localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_LOAD = 3'd2,
                          S_RUN = 3'd3, S_PAUSE = 3'd4, S_ALARM = 3'd5;

   typedef struct {
      logic [4:0]  btns;      // {start, set, up, down, tick}
      logic [15:0] cnt;       // {min_tens, min_ones, sec_tens, sec_ones}
      logic [2:0]  e_state;
      logic        e_load, e_en, e_edit, e_alarm;
      logic [1:0]  e_sel;
      logic [15:0] e_preset;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   egg_timer_if u_if ();

   egg_timer_ctrl #(.ALARM_SECONDS(10), .MIN_TENS_MAX(9)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   task automatic chk(input string name, input int idx, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step%0d actual=%0h required=%0h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input logic [2:0] st, input logic ld,
                            input logic en, input logic ed, input logic al,
                            input logic [1:0] sel, input logic [15:0] pre);
      chk("state", idx, 16'(u_if.state), 16'(st));
      chk("load", idx, 16'(u_if.load), 16'(ld));
      chk("enable", idx, 16'(u_if.enable), 16'(en));
      chk("editing", idx, 16'(u_if.editing), 16'(ed));
      chk("alarm", idx, 16'(u_if.alarm), 16'(al));
      chk("edit_sel", idx, 16'(u_if.edit_sel), 16'(sel));
      chk("preset", idx, {u_if.preset_min_tens, u_if.preset_min_ones,
                          u_if.preset_sec_tens, u_if.preset_sec_ones}, pre);
   endtask

   task automatic drive(input logic [4:0] b, input logic [15:0] c);
      {u_if.btn_start, u_if.btn_set, u_if.btn_up, u_if.btn_down, u_if.tick_1hz} = b;
      {u_if.cnt_min_tens, u_if.cnt_min_ones, u_if.cnt_sec_tens, u_if.cnt_sec_ones} = c;
   endtask

   // One clock with the given pulses; pulses drop right after the edge.
   task automatic cyc(input logic [4:0] b, input logic [15:0] c);
      drive(b, c);
      @(posedge clk);
      #1;
      drive(5'b00000, c);
      $display("step btns=%05b cnt=%04h -> state=%0d load=%0b en=%0b alarm=%0b",
               b, c, u_if.state, u_if.load, u_if.enable, u_if.alarm);
   endtask

   task automatic add(input logic [4:0] b, input logic [15:0] c, input logic [2:0] st,
                      input logic ld, input logic en, input logic ed, input logic al,
                      input logic [1:0] sel, input logic [15:0] pre);
      vec_t v;
      v.btns = b; v.cnt = c; v.e_state = st; v.e_load = ld; v.e_en = en;
      v.e_edit = ed; v.e_alarm = al; v.e_sel = sel; v.e_preset = pre;
      vecs.push_back(v);
   endtask

   initial begin
      //  btns{st,se,up,dn,tk} cnt      state   ld en ed al sel preset
      add(5'b00000, 16'h0000, S_IDLE,  0, 0, 0, 0, 0, 16'h0000);
      add(5'b01000, 16'h0000, S_SET,   0, 0, 1, 0, 0, 16'h0000);
      add(5'b00010, 16'h0000, S_SET,   0, 0, 1, 0, 0, 16'h9000); // min_tens 0-1 -> 9
      add(5'b00100, 16'h0000, S_SET,   0, 0, 1, 0, 0, 16'h0000); // 9+1 -> 0
      add(5'b01000, 16'h0000, S_SET,   0, 0, 1, 0, 1, 16'h0000);
      add(5'b00100, 16'h0000, S_SET,   0, 0, 1, 0, 1, 16'h0100);
      add(5'b01000, 16'h0000, S_SET,   0, 0, 1, 0, 2, 16'h0100);
      add(5'b00010, 16'h0000, S_SET,   0, 0, 1, 0, 2, 16'h0150); // sec_tens 0-1 -> 5
      add(5'b00100, 16'h0000, S_SET,   0, 0, 1, 0, 2, 16'h0100); // 5+1 -> 0
      add(5'b00100, 16'h0000, S_SET,   0, 0, 1, 0, 2, 16'h0110);
      add(5'b00100, 16'h0000, S_SET,   0, 0, 1, 0, 2, 16'h0120);
      add(5'b00100, 16'h0000, S_SET,   0, 0, 1, 0, 2, 16'h0130);
      add(5'b01000, 16'h0000, S_SET,   0, 0, 1, 0, 3, 16'h0130);
      add(5'b00010, 16'h0000, S_SET,   0, 0, 1, 0, 3, 16'h0139); // sec_ones 0-1 -> 9
      add(5'b00100, 16'h0000, S_SET,   0, 0, 1, 0, 3, 16'h0130);
      add(5'b01100, 16'h0000, S_LOAD,  1, 0, 0, 0, 0, 16'h0130); // 5th set beats up
      add(5'b00100, 16'h0000, S_LOAD,  1, 0, 0, 0, 0, 16'h0130); // ignored
      add(5'b00001, 16'h0000, S_IDLE,  0, 0, 0, 0, 0, 16'h0130); // tick ends load
      add(5'b10000, 16'h0000, S_IDLE,  0, 0, 0, 0, 0, 16'h0130); // zero counter
      add(5'b10000, 16'h0003, S_RUN,   0, 1, 0, 0, 0, 16'h0130);
      add(5'b10000, 16'h0002, S_PAUSE, 0, 0, 0, 0, 0, 16'h0130);
      add(5'b00100, 16'h0002, S_PAUSE, 0, 0, 0, 0, 0, 16'h0130);
      add(5'b10000, 16'h0002, S_RUN,   0, 1, 0, 0, 0, 16'h0130);
      add(5'b00001, 16'h0001, S_RUN,   0, 1, 0, 0, 0, 16'h0130);
      add(5'b00000, 16'h0000, S_ALARM, 0, 0, 0, 1, 0, 16'h0130);
      add(5'b00010, 16'h0000, S_IDLE,  0, 0, 0, 0, 0, 16'h0130); // consumed
      add(5'b10000, 16'h0002, S_RUN,   0, 1, 0, 0, 0, 16'h0130);
      add(5'b10000, 16'h0000, S_ALARM, 0, 0, 0, 1, 0, 16'h0130); // zero beats start
      add(5'b00001, 16'h0000, S_ALARM, 0, 0, 0, 1, 0, 16'h0130);
      add(5'b01000, 16'h0000, S_IDLE,  0, 0, 0, 0, 0, 16'h0130); // not SET
      add(5'b01000, 16'h0000, S_SET,   0, 0, 1, 0, 0, 16'h0130);
      add(5'b11000, 16'h0000, S_LOAD,  1, 0, 0, 0, 0, 16'h0130); // start beats set
      add(5'b00001, 16'h0000, S_IDLE,  0, 0, 0, 0, 0, 16'h0130);
      add(5'b10000, 16'h0005, S_RUN,   0, 1, 0, 0, 0, 16'h0130);
      add(5'b10000, 16'h0005, S_PAUSE, 0, 0, 0, 0, 0, 16'h0130);
      add(5'b01000, 16'h0005, S_SET,   0, 0, 1, 0, 0, 16'h0130);
      add(5'b10000, 16'h0005, S_LOAD,  1, 0, 0, 0, 0, 16'h0130);
      add(5'b00001, 16'h0005, S_IDLE,  0, 0, 0, 0, 0, 16'h0130);

      reset = 1'b1;
      drive(5'b00000, 16'h0000);
      repeat (3) @(posedge clk);
      #1;
      check_all(0, S_IDLE, 0, 0, 0, 0, 0, 16'h0000);
      reset = 1'b0;

      foreach (vecs[i]) begin
         cyc(vecs[i].btns, vecs[i].cnt);
         check_all(i + 1, vecs[i].e_state, vecs[i].e_load, vecs[i].e_en,
                   vecs[i].e_edit, vecs[i].e_alarm, vecs[i].e_sel, vecs[i].e_preset);
      end

      // Reset in the middle of LOADING clears outputs without a clock edge.
      cyc(5'b01000, 16'h0000);
      cyc(5'b10000, 16'h0000);
      chk("load_before_reset", 100, 16'(u_if.load), 16'd1);
      #2 reset = 1'b1;
      #1;
      chk("load_async_reset", 101, 16'(u_if.load), 16'd0);
      chk("state_async_reset", 101, 16'(u_if.state), 16'(S_IDLE));
      chk("preset_async_reset", 101, {u_if.preset_min_tens, u_if.preset_min_ones,
                                      u_if.preset_sec_tens, u_if.preset_sec_ones}, 16'h0000);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      cyc(5'b00001, 16'h0000);
      check_all(102, S_IDLE, 0, 0, 0, 0, 0, 16'h0000);
      cyc(5'b00000, 16'h0000);
      check_all(103, S_IDLE, 0, 0, 0, 0, 0, 16'h0000);

`ifdef EGG_TIMER_ALARM_TIMEOUT_EN
      cyc(5'b10000, 16'h0001);
      chk("timeout_run", 200, 16'(u_if.state), 16'(S_RUN));
      cyc(5'b00000, 16'h0000);
      chk("timeout_alarm", 201, 16'(u_if.alarm), 16'd1);
      for (int k = 1; k <= 9; k++) begin
         cyc(5'b00001, 16'h0000);
         cyc(5'b00000, 16'h0000);
         chk("timeout_hold", 201 + k, 16'(u_if.state), 16'(S_ALARM));
      end
      cyc(5'b00001, 16'h0000);
      chk("timeout_state", 211, 16'(u_if.state), 16'(S_IDLE));
      chk("timeout_alarm_clr", 211, 16'(u_if.alarm), 16'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/egg_timer_ctrl.md
# egg_timer_ctrl

Control FSM for the egg timer. It sits between the debounced front-panel buttons and the BCD down-counter (`timer`). It owns the preset time, edits the preset digit by digit, and drives `load` and `enable` into the counter. It also detects expiry from the counter's digit outputs and raises the alarm. It runs on the 100 MHz system clock and treats the 1 Hz pulse as a single-cycle strobe.

## Interface
Parameters:
- `ALARM_SECONDS`, default 10: seconds the alarm stays asserted before auto-clear (only with `ALARM_TIMEOUT_EN`).
- `MIN_TENS_MAX`, default 9: highest value allowed for the minute-tens digit.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: reset, asynchronous, active-high.
- `tick_1hz` in 1: one-`clk` strobe, coincident with the `timer` clock rising edge.
- `btn_start` in 1: debounced one-cycle pulse, start/pause.
- `btn_set` in 1: debounced pulse, enter edit mode / advance digit.
- `btn_up` in 1: debounced pulse, increment the selected digit.
- `btn_down` in 1: debounced pulse, decrement the selected digit.
- `cnt_min_tens`, `cnt_min_ones`, `cnt_sec_tens`, `cnt_sec_ones` in 4 each: live counter digits from `timer`.
- `load` out 1: counter load request.
- `enable` out 1: counter count enable.
- `preset_min_tens`, `preset_min_ones`, `preset_sec_tens`, `preset_sec_ones` out 4 each: preset digits, fed to the `timer` load inputs.
- `edit_sel` out 2: selected digit. 0 = min_tens, 1 = min_ones, 2 = sec_tens, 3 = sec_ones.
- `editing` out 1: high in SET; display blinks the `edit_sel` digit.
- `alarm` out 1: expiry indication.
- `state` out 3: current FSM state, for debug and LEDs.

## Operation
- States: IDLE, SET, LOADING, RUN, PAUSE, ALARM.
- Reset values:
  - FSM goes to IDLE.
  - All presets = 0, `edit_sel` = 0.
  - `load`, `enable`, `editing`, `alarm` = 0.
  - Alarm timer = 0.
- Button priority when pulses coincide: start > set > up > down. Only one button action is taken per cycle.
- IDLE:
  - `btn_set` goes to SET with `edit_sel` = 0. Presets are retained.
  - `btn_start` goes to RUN only if the counter digits are nonzero; otherwise it is ignored.
- SET (`editing` = 1):
  - `btn_up` / `btn_down` change the selected preset digit with wrap-around.
  - Digit limits: ones digits 0..9, sec_tens 0..5, min_tens 0..`MIN_TENS_MAX`.
  - `btn_set` advances `edit_sel`. When `edit_sel` = 3, `btn_set` goes to LOADING and resets `edit_sel` to 0.
  - `btn_start` in SET goes to LOADING immediately.
- LOADING:
  - `load` = 1 until the first `tick_1hz` seen in this state.
  - The cycle after that tick: `load` = 0 and the FSM goes to IDLE.
  - Buttons are ignored.
- RUN:
  - `enable` = 1.
  - `btn_start` goes to PAUSE.
  - All four counter digits = 0 goes to ALARM. Zero detection takes priority over a same-cycle `btn_start`.
- PAUSE:
  - `enable` = 0.
  - `btn_start` goes to RUN.
  - `btn_set` goes to SET.
- ALARM:
  - `alarm` = 1, `enable` = 0.
  - Any button pulse goes to IDLE. The pulse is consumed and causes no other action.
- All-zero preset loaded, then start pressed: stays in IDLE, no alarm.

## Timing
- All outputs are registered and change one `clk` after the causing input.
- `load` is held across at least one `tick_1hz`, so the slow-clocked counter samples it. Worst-case load latency is 1 s plus 1 `clk`.
- `enable` rises and falls 1 `clk` after the accepted `btn_start`. The counter acts on the next `tick_1hz`.
- Expiry: `alarm` rises 1 `clk` after the counter digits read 0000.
- A reset mid-operation (any state) clears everything asynchronously. No load or enable glitch occurs after release.

## Configuration
- Macro: `EGG_TIMER_ALARM_TIMEOUT_EN`.
- Defined:
  - ALARM counts `tick_1hz` strobes in an 8-bit counter.
  - At `ALARM_SECONDS` ticks, the FSM goes to IDLE and `alarm` clears.
  - The counter clears on entry to ALARM.
- Undefined: the alarm persists until a button press. The counter logic is absent.

## Structure
- `egg_timer_pkg` holds:
  - the state enum (3-bit encoding);
  - the `edit_sel` encodings;
  - the digit-limit constants (`ONES_MAX` = 9, `SEC_TENS_MAX` = 5).
- Sub-module `bcd_digit_wrap`: one preset digit with up/down/wrap logic and a max-value input. It is instantiated four times.

## Test plan
- Reset, then set presets to 01:30 via set/up/down, then 5th `btn_set` -> LOADING with `load` high until the next tick. Presets read 0,1,3,0. FSM returns to IDLE.
- sec_tens = 5 plus `btn_up` -> 0. sec_ones = 0 plus `btn_down` -> 9. min_tens = 0 plus `btn_down` -> `MIN_TENS_MAX`.
- IDLE with counter 00:03, `btn_start` -> RUN with `enable` = 1. Counter reaches 0000 -> `alarm` = 1 one `clk` later, `enable` = 0.
- RUN, `btn_start` -> PAUSE with `enable` = 0. `btn_start` again -> RUN. Same-cycle `btn_start` and counter 0000 -> ALARM.
- IDLE with counter 0000, `btn_start` -> FSM stays in IDLE, `alarm` = 0.
- With `EGG_TIMER_ALARM_TIMEOUT_EN`: ALARM plus 10 ticks -> IDLE, `alarm` = 0. Reset asserted during LOADING -> `load` = 0 immediately, state IDLE.
